mem_stage_ctrl: RTL and testbench

- Consumer at the far end of the EX/MEM pipeline buffer.
- Takes the buffered ALU result, store data, destination register, op code and valid bit, and performs the MEM-stage work:
  - ALU results pass through in one cycle.
  - Loads and stores are issued to a multi-cycle data memory over a req/ack handshake, with an upstream stall.
- Drives the MEM/WB payload and a sticky error flag for misaligned or timed-out accesses.

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/mem_wait_timer.sv | 30 +++
 rtl/mem_stage_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM-stage controller: op codes, FSM encoding, widths.
package mem_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 8;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ALU = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_SW  = 3'd3;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait counter for an outstanding memory access; flags the last allowed BUSY cycle.
module mem_wait_timer
    import mem_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    logic [CNT_W-1:0] count;

    // Counter clears (loads zero) on BUSY entry and advances on each un-acked BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // Count starts at 0 in the first BUSY cycle, so MAX_WAIT-1 marks the MAX_WAIT-th cycle.
    assign expired_c = (count == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: ALU pass-through, LW/SW over a req/ack data-memory port.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [XLEN-1:0]  alu_result_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [REG_W-1:0] rsd_i,
    input  logic [2:0]       Op_i,
    input  logic             valid_i,
    output logic             stall_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [XLEN-1:0]  mem_addr_o,
    output logic [XLEN-1:0]  mem_wdata_o,
    input  logic             mem_ack_i,
    input  logic [XLEN-1:0]  mem_rdata_i,
    output logic             wb_valid_o,
    output logic             wb_we_o,
    output logic [REG_W-1:0] wb_rd_o,
    output logic [XLEN-1:0]  wb_data_o,
    output logic             err_o
);

    logic [0:0]       state_q, state_d;
    logic             req_d, we_d, wbv_d, wbwe_d, err_d;
    logic [XLEN-1:0]  addr_d, wdata_d, wbdata_d;
    logic [REG_W-1:0] rd_q, rd_d, wbrd_d;
    logic             stall_c, timer_clr, timer_en, expired_c;

    mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk       (clk_i),
        .rst       (rst_i),
        .clr       (timer_clr),
        .en        (timer_en),
        .expired_c (expired_c)
    );

    // State register and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rd_q        <= '0;
            wb_valid_o  <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_rd_o     <= '0;
            wb_data_o   <= '0;
            err_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_o   <= req_d;
            mem_we_o    <= we_d;
            mem_addr_o  <= addr_d;
            mem_wdata_o <= wdata_d;
            rd_q        <= rd_d;
            wb_valid_o  <= wbv_d;
            wb_we_o     <= wbwe_d;
            wb_rd_o     <= wbrd_d;
            wb_data_o   <= wbdata_d;
            err_o       <= err_d;
        end
    end

    // Next-state, next-output and stall decode.
    always_comb begin
        state_d   = state_q;
        req_d     = mem_req_o;
        we_d      = mem_we_o;
        addr_d    = mem_addr_o;
        wdata_d   = mem_wdata_o;
        rd_d      = rd_q;
        wbv_d     = 1'b0;
        wbwe_d    = wb_we_o;
        wbrd_d    = wb_rd_o;
        wbdata_d  = wb_data_o;
        err_d     = err_o;
        stall_c   = 1'b0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    case (Op_i)
                        OP_ALU: begin
                            wbv_d    = 1'b1;
                            wbrd_d   = rsd_i;
                            wbdata_d = alu_result_i;
                            wbwe_d   = (rsd_i != '0);
                        end
                        OP_LW, OP_SW: begin
                            if (alu_result_i[1:0] == 2'b00) begin
                                stall_c   = 1'b1;
                                req_d     = 1'b1;
                                we_d      = (Op_i == OP_SW);
                                addr_d    = alu_result_i;
                                wdata_d   = rs2_data_i;
                                rd_d      = rsd_i;
                                timer_clr = 1'b1;
                                state_d   = BUSY;
                            end else begin
                                err_d    = 1'b1;
                                wbv_d    = 1'b1;
                                wbwe_d   = 1'b0;
                                wbrd_d   = rsd_i;
                                wbdata_d = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    // Ack takes priority over a coincident timeout.
                    req_d   = 1'b0;
                    wbv_d   = 1'b1;
                    wbrd_d  = rd_q;
                    state_d = IDLE;
                    if (mem_we_o) begin
                        wbwe_d   = 1'b0;
                        wbdata_d = '0;
                    end else begin
                        wbwe_d   = (rd_q != '0);
                        wbdata_d = mem_rdata_i;
                    end
                end else if (expired_c) begin
                    req_d    = 1'b0;
                    err_d    = 1'b1;
                    wbv_d    = 1'b1;
                    wbwe_d   = 1'b0;
                    wbrd_d   = rd_q;
                    wbdata_d = '0;
                    state_d  = IDLE;
                end else begin
                    stall_c  = 1'b1;
                    timer_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stall is combinational; forced low while reset is held.
    assign stall_o = stall_c & ~rst_i;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed ops, queued write-back expectations.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] alu_result_i, rs2_data_i, mem_addr_o, mem_wdata_o, mem_rdata_i, wb_data_o;
    logic [4:0]  rsd_i, wb_rd_o;
    logic [2:0]  Op_i;
    logic        valid_i, stall_o, mem_req_o, mem_we_o, mem_ack_i;
    logic        wb_valid_o, wb_we_o, err_o;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
    } exp_t;

    exp_t exp_q[$];

    mem_stage_ctrl #(.MAX_WAIT(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .alu_result_i (alu_result_i),
        .rs2_data_i   (rs2_data_i),
        .rsd_i        (rsd_i),
        .Op_i         (Op_i),
        .valid_i      (valid_i),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .wb_valid_o   (wb_valid_o),
        .wb_we_o      (wb_we_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd);
        valid_i      = v;
        Op_i         = op;
        alu_result_i = a;
        rs2_data_i   = d;
        rsd_i        = rd;
    endtask

    task automatic push(input logic we, input logic [4:0] rd, input logic [31:0] data,
                        input logic chk);
        exp_t e;
        e.we = we; e.rd = rd; e.data = data; e.chk_data = chk;
        exp_q.push_back(e);
    endtask

    // Monitor: every write-back beat must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_i === 1'b0 && wb_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wb_unexpected: got rd=%0d data=0x%08h expected no beat",
                         wb_rd_o, wb_data_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wb_we", 32'(wb_we_o), 32'(e.we));
                check("wb_rd", 32'(wb_rd_o), 32'(e.rd));
                if (e.chk_data) check("wb_data", wb_data_o, e.data);
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_stall"}, 32'(stall_o), 32'd0);
        check({tag, "_req"},   32'(mem_req_o), 32'd0);
        check({tag, "_we"},    32'(mem_we_o), 32'd0);
        check({tag, "_addr"},  mem_addr_o, 32'd0);
        check({tag, "_wdata"}, mem_wdata_o, 32'd0);
        check({tag, "_wbv"},   32'(wb_valid_o), 32'd0);
        check({tag, "_wbwe"},  32'(wb_we_o), 32'd0);
        check({tag, "_wbrd"},  32'(wb_rd_o), 32'd0);
        check({tag, "_wbd"},   wb_data_o, 32'd0);
        check({tag, "_err"},   32'(err_o), 32'd0);
    endtask

    initial begin
        rst_i       = 1'b1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'd0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        tick();
        tick();
        check_idle_outputs("reset");
        drive(1'b1, 3'd2, 32'h100, 32'd0, 5'd1);
        #1 check("reset_stall_gated", 32'(stall_o), 32'd0);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        rst_i = 1'b0;
        tick();

        // ALU pass-through, one-cycle latency, never stalls
        drive(1'b1, 3'd1, 32'h0000_1234, 32'd0, 5'd5);
        push(1'b1, 5'd5, 32'h1234, 1'b1);
        #1 check("alu_stall", 32'(stall_o), 32'd0);
        tick();
        check("alu_wbv", 32'(wb_valid_o), 32'd1);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        tick();
        check("nop_wbv", 32'(wb_valid_o), 32'd0);
        check("nop_hold_rd", 32'(wb_rd_o), 32'd5);

        // LW 0x100, ack on the third request cycle
        drive(1'b1, 3'd2, 32'h100, 32'd0, 5'd7);
        push(1'b1, 5'd7, 32'hDEADBEEF, 1'b1);
        #1 check("lw_stall_c0", 32'(stall_o), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("lw_req", 32'(mem_req_o), 32'd1);
            check("lw_addr", mem_addr_o, 32'h100);
            check("lw_we", 32'(mem_we_o), 32'd0);
            check("lw_wbv_busy", 32'(wb_valid_o), 32'd0);
            if (c == 3) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = 32'hDEADBEEF;
            end
            #1 check("lw_stall", 32'(stall_o), (c == 3) ? 32'd0 : 32'd1);
        end
        tick();
        mem_ack_i = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        check("lw_wbv", 32'(wb_valid_o), 32'd1);
        check("lw_req_drop", 32'(mem_req_o), 32'd0);
        tick();

        // SW 0x204, ack in first request cycle
        drive(1'b1, 3'd3, 32'h204, 32'hCAFE0001, 5'd9);
        push(1'b0, 5'd9, 32'd0, 1'b1);
        tick();
        check("sw_req", 32'(mem_req_o), 32'd1);
        check("sw_we", 32'(mem_we_o), 32'd1);
        check("sw_addr", mem_addr_o, 32'h204);
        check("sw_wdata", mem_wdata_o, 32'hCAFE0001);
        mem_ack_i = 1'b1;
        #1 check("sw_stall_ack", 32'(stall_o), 32'd0);
        tick();
        mem_ack_i = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        check("sw_wbv", 32'(wb_valid_o), 32'd1);
        tick();

        // LW to x0: completes without register write
        drive(1'b1, 3'd2, 32'h300, 32'd0, 5'd0);
        push(1'b0, 5'd0, 32'h11223344, 1'b1);
        tick();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h11223344;
        tick();
        mem_ack_i = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        tick();

        // Ack coincident with the timeout cycle: ack wins, no error
        drive(1'b1, 3'd2, 32'h308, 32'd0, 5'd8);
        push(1'b1, 5'd8, 32'h0BADF00D, 1'b1);
        for (int c = 1; c <= 4; c++) tick();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0BADF00D;
        tick();
        mem_ack_i = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        check("race_err", 32'(err_o), 32'd0);
        tick();

        // Timeout: MAX_WAIT=4, no ack
        drive(1'b1, 3'd2, 32'h400, 32'd0, 5'd4);
        push(1'b0, 5'd4, 32'd0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("to_req", 32'(mem_req_o), 32'd1);
            #1 check("to_stall", 32'(stall_o), (c == 4) ? 32'd0 : 32'd1);
        end
        tick();
        check("to_req_rel", 32'(mem_req_o), 32'd0);
        check("to_err", 32'(err_o), 32'd1);
        check("to_wbv", 32'(wb_valid_o), 32'd1);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        check("late_ack_wbv", 32'(wb_valid_o), 32'd0);
        check("late_ack_req", 32'(mem_req_o), 32'd0);

        // Misaligned LW 0x102: error, no request, no stall
        drive(1'b1, 3'd2, 32'h102, 32'd0, 5'd3);
        push(1'b0, 5'd3, 32'd0, 1'b0);
        #1 check("mis_stall", 32'(stall_o), 32'd0);
        tick();
        check("mis_req", 32'(mem_req_o), 32'd0);
        check("mis_err", 32'(err_o), 32'd1);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        tick();
        check("mis_err_sticky", 32'(err_o), 32'd1);

        // Reset while BUSY abandons the access
        drive(1'b1, 3'd2, 32'h500, 32'd0, 5'd6);
        tick();
        check("rb_req", 32'(mem_req_o), 32'd1);
        rst_i = 1'b1;
        #1 check("rb_stall_comb", 32'(stall_o), 32'd0);
        tick();
        check_idle_outputs("rb");
        rst_i = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        tick();

        // ALU after reset still works
        drive(1'b1, 3'd1, 32'hA5A5_0000, 32'd0, 5'd31);
        push(1'b1, 5'd31, 32'hA5A5_0000, 1'b1);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        tick();
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
